// File: rtl/cnstr_sample_driver.sv
// Constrained-random sample driver: builds W-bit candidates from a Galois LFSR,
// hands each to an external checker and streams the accepted ones downstream.
//   state | meaning
//   IDLE  | waiting for start / seed_load
//   GEN   | one 32-bit LFSR word per cycle into cand_out
//   CHECK | consume checker verdict, accept or count a reject
//   OUT   | hold accepted sample until downstream takes it
//   FIN   | one-cycle done pulse
module cnstr_sample_driver #(
    parameter int          W         = 64,
    parameter int          MAX_TRIES = 1024,
    parameter logic [31:0] DEF_SEED  = 32'hACE1_0001
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          seed_load,
    input  logic [31:0]   seed_in,
    input  logic [15:0]   num_samples,
    output logic [W-1:0]  cand_out,
    input  logic          chk_result,
    output logic          sample_valid,
    output logic [W-1:0]  sample_data,
    input  logic          sample_ready,
    output logic          busy,
    output logic          done,
    output logic          fail,
    output logic [15:0]   accept_cnt,
    output logic [31:0]   try_cnt
);

    localparam int          NW   = W / 32;
    localparam int          WIDX = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [31:0] MASK = 32'h8020_0003;

    typedef enum logic [2:0] {IDLE, GEN, CHECK, OUT, FIN} state_t;

    state_t            state_q;
    logic [31:0]       lfsr_q;
    logic [31:0]       lfsr_d;
    logic [WIDX-1:0]   word_q;
    logic [W-1:0]      cand_q;
    logic [W-1:0]      sample_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic              fail_q;
    logic [15:0]       acc_q;
    logic [15:0]       acc_d;
    logic [31:0]       try_q;
    logic [31:0]       rej_q;
    logic [31:0]       rej_d;
    logic [15:0]       nsamp_q;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? MASK : 32'h0);
        rej_d  = rej_q + 32'd1;
        acc_d  = acc_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= DEF_SEED;
            word_q   <= '0;
            cand_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fail_q   <= 1'b0;
            acc_q    <= '0;
            try_q    <= '0;
            rej_q    <= '0;
            nsamp_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // a seed loaded in the start cycle is what GEN advances from
                    if (seed_load)
                        lfsr_q <= (seed_in == 32'h0) ? DEF_SEED : seed_in;
                    if (start) begin
                        nsamp_q <= num_samples;
                        acc_q   <= '0;
                        try_q   <= '0;
                        rej_q   <= '0;
                        fail_q  <= 1'b0;
                        word_q  <= '0;
                        busy_q  <= 1'b1;
                        if (num_samples == 16'd0) begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            state_q <= GEN;
                        end
                    end
                end
                GEN: begin
                    lfsr_q                  <= lfsr_d;
                    cand_q[32*word_q +: 32] <= lfsr_d;
                    if (word_q == WIDX'(NW - 1)) begin
                        word_q  <= '0;
                        state_q <= CHECK;
                    end else begin
                        word_q <= word_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (try_q != 32'hFFFF_FFFF)
                        try_q <= try_q + 32'd1;
                    if (chk_result) begin
                        sample_q <= cand_q;
                        valid_q  <= 1'b1;
                        state_q  <= OUT;
                    end else begin
                        rej_q <= rej_d;
                        if (rej_d >= 32'(MAX_TRIES)) begin
                            fail_q  <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            state_q <= GEN;
                        end
                    end
                end
                OUT: begin
                    if (sample_ready) begin
                        valid_q <= 1'b0;
                        acc_q   <= acc_d;
                        rej_q   <= '0;
                        if (acc_d == nsamp_q) begin
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end else begin
                            state_q <= GEN;
                        end
                    end
                end
                FIN: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cand_out     = cand_q;
    assign sample_data  = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign accept_cnt   = acc_q;
    assign try_cnt      = try_q;

endmodule

// File: tb/tb_cnstr_sample_driver.sv
// Directed bench for cnstr_sample_driver (W=64, MAX_TRIES=4) with a stub checker.
module tb_cnstr_sample_driver;

    localparam logic [31:0] DEF = 32'hACE1_0001;

    logic        clk = 1'b0;
    logic        rst_n, start, seed_load, chk_result, sample_ready;
    logic [31:0] seed_in;
    logic [15:0] num_samples;
    logic [63:0] cand_out, sample_data;
    logic        sample_valid, busy, done, fail;
    logic [15:0] accept_cnt;
    logic [31:0] try_cnt;
    logic [1:0]  chk_mode;   // 0: accept all, 1: reject all, 2: accept odd candidates

    int checks = 0;
    int errors = 0;
    int nval, ndone, lat;
    logic [63:0] samples [8];
    logic [63:0] exp_s;
    logic [31:0] ms, w0, w1;
    logic [63:0] held_data, held_cand;
    bit          stable;

    cnstr_sample_driver #(.W(64), .MAX_TRIES(4), .DEF_SEED(DEF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed_load(seed_load),
        .seed_in(seed_in), .num_samples(num_samples), .cand_out(cand_out),
        .chk_result(chk_result), .sample_valid(sample_valid), .sample_data(sample_data),
        .sample_ready(sample_ready), .busy(busy), .done(done), .fail(fail),
        .accept_cnt(accept_cnt), .try_cnt(try_cnt)
    );

    always #5 clk = ~clk;

    assign chk_result = (chk_mode == 2'd0) ? 1'b1 :
                        (chk_mode == 2'd1) ? 1'b0 : cand_out[0];

    function automatic logic [31:0] adv(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] n);
        num_samples = n;
        start       = 1'b1;
        step();
        start     = 1'b0;
        seed_load = 1'b0;
    endtask

    task automatic collect(input int max_cyc);
        bit fin;
        fin   = 0;
        nval  = 0;
        ndone = 0;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            if (sample_valid && sample_ready) begin
                if (nval < 8) samples[nval] = sample_data;
                nval++;
            end
            if (done) ndone++;
            if (ndone > 0 && !busy) fin = 1;
            else step();
        end
        chk("run_complete", 64'(fin), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; seed_load = 1'b0; seed_in = '0;
        num_samples = '0; sample_ready = 1'b1; chk_mode = 2'd0;
        step(); step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fail", 64'(fail), 64'd0);
        chk("rst_valid", 64'(sample_valid), 64'd0);
        chk("rst_acc", 64'(accept_cnt), 64'd0);
        chk("rst_try", 64'(try_cnt), 64'd0);
        chk("rst_cand", cand_out, 64'd0);
        chk("rst_data", sample_data, 64'd0);
        rst_n = 1'b1;
        step();

        // accept-all, three samples from the reset seed
        do_start(16'd3);
        lat = 1;
        while (!sample_valid && lat < 50) begin step(); lat++; end
        chk("first_latency", 64'(lat), 64'd4);
        collect(200);
        chk("t1_nval", 64'(nval), 64'd3);
        chk("t1_sample0_hand", samples[0], 64'hEB084002_D6508003);
        ms = DEF;
        for (int i = 0; i < 3; i++) begin
            w0 = adv(ms); w1 = adv(w0); ms = w1;
            chk($sformatf("t1_sample%0d", i), samples[i], {w1, w0});
        end
        chk("t1_try", 64'(try_cnt), 64'd3);
        chk("t1_acc", 64'(accept_cnt), 64'd3);
        chk("t1_fail", 64'(fail), 64'd0);
        chk("t1_done_pulses", 64'(ndone), 64'd1);

        // reject-all aborts after MAX_TRIES
        chk_mode = 2'd1;
        do_start(16'd1);
        collect(200);
        chk("t2_try", 64'(try_cnt), 64'd4);
        chk("t2_fail", 64'(fail), 64'd1);
        chk("t2_done_pulses", 64'(ndone), 64'd1);
        chk("t2_nval", 64'(nval), 64'd0);
        chk("t2_acc", 64'(accept_cnt), 64'd0);

        // backpressure: seed 2 gives first candidate {8020_0003, 0000_0001} (odd, accepted)
        seed_in = 32'h2; seed_load = 1'b1;
        step();
        seed_load = 1'b0;
        chk_mode = 2'd2; sample_ready = 1'b0;
        do_start(16'd1);
        lat = 1;
        while (!sample_valid && lat < 50) begin step(); lat++; end
        chk("t3_valid", 64'(sample_valid), 64'd1);
        chk("t3_data", sample_data, 64'h80200003_00000001);
        held_data = sample_data; held_cand = cand_out; stable = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!sample_valid || sample_data !== held_data || cand_out !== held_cand) stable = 0;
        end
        chk("t3_stable", 64'(stable), 64'd1);
        sample_ready = 1'b1;
        step();
        chk("t3_acc", 64'(accept_cnt), 64'd1);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_valid_drop", 64'(sample_valid), 64'd0);
        chk("t3_try", 64'(try_cnt), 64'd1);
        step();
        chk("t3_idle", 64'(busy), 64'd0);

        // zero samples: done in the following cycle, LFSR untouched
        chk_mode = 2'd0;
        do_start(16'd0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_acc", 64'(accept_cnt), 64'd0);
        chk("t4_try", 64'(try_cnt), 64'd0);
        chk("t4_fail", 64'(fail), 64'd0);
        step();
        chk("t4_done_clear", 64'(done), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);
        do_start(16'd1);
        collect(100);
        chk("t4_lfsr_kept", samples[0], 64'h60180001_C0300002);

        // zero seed loaded together with start replays the reset sequence
        seed_in = 32'h0; seed_load = 1'b1;
        do_start(16'd3);
        collect(200);
        chk("t5_nval", 64'(nval), 64'd3);
        ms = DEF;
        for (int i = 0; i < 3; i++) begin
            w0 = adv(ms); w1 = adv(w0); ms = w1;
            chk($sformatf("t5_sample%0d", i), samples[i], {w1, w0});
        end

        // reset while a sample is pending in OUT
        sample_ready = 1'b0;
        do_start(16'd2);
        lat = 1;
        while (!sample_valid && lat < 50) begin step(); lat++; end
        chk("t6_in_out", 64'(sample_valid), 64'd1);
        rst_n = 1'b0;
        step();
        chk("t6_valid", 64'(sample_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_acc", 64'(accept_cnt), 64'd0);
        chk("t6_try", 64'(try_cnt), 64'd0);
        chk("t6_cand", cand_out, 64'd0);
        rst_n = 1'b1; sample_ready = 1'b1;
        step();
        do_start(16'd1);
        collect(100);
        chk("t6_fresh_sample", samples[0], 64'hEB084002_D6508003);
        chk("t6_fresh_acc", 64'(accept_cnt), 64'd1);
        chk("t6_fresh_done", 64'(ndone), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnstr_sample_driver.md
CNSTR_SAMPLE_DRIVER -- requirements
Module: cnstr_sample_driver

Interface
Parameters:
REQ-001 SHALL have parameter W, default 64: candidate width, a multiple of 32, range 32..1024.
REQ-002 SHALL have parameter MAX_TRIES, default 1024: rejected candidates allowed per sample before abort.
REQ-003 SHALL have parameter DEF_SEED, default 32'hACE1_0001: LFSR seed used at reset and whenever a zero seed is loaded.

Ports (name  direction  width  meaning):
REQ-004 SHALL have clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have rst_n  in  1  reset. One clock; reset is synchronous and active-low.
REQ-006 SHALL have start  in  1  begin a run; honoured only in IDLE.
REQ-007 SHALL have seed_load  in  1  load seed_in into the LFSR; honoured only in IDLE.
REQ-008 SHALL have seed_in  in  32  seed value.
REQ-009 SHALL have num_samples  in  16  accepted samples required; captured on start.
REQ-010 SHALL have cand_out  out  W  registered candidate vector, driven to the external combinational constraint checker.
REQ-011 SHALL have chk_result  in  1  checker verdict for the current cand_out (1 = all constraints satisfied).
REQ-012 SHALL have sample_valid, sample_data  out  1, W  accepted-sample stream; sample_ready  in  1  downstream ready.
REQ-013 SHALL have busy, done, fail  out  1 each; accept_cnt  out  16; try_cnt  out  32 (total candidates checked in the run).

Function
REQ-014 SHALL implement FSM states IDLE, GEN, CHECK, OUT, FIN.
REQ-015 SHALL use a 32-bit Galois LFSR, mask 32'h8020_0003, advancing exactly once per GEN cycle and at no other time.
REQ-016 GEN SHALL last W/32 cycles; in cycle k, the advanced LFSR value SHALL be written to cand_out[32k+31:32k], and after the last word the FSM SHALL go to CHECK.
REQ-017 CHECK SHALL last one cycle: try_cnt += 1; if chk_result=1, sample_data <= cand_out and go to OUT; else per-sample rejects += 1.
REQ-018 On a reject in CHECK, if per-sample rejects reach MAX_TRIES, the FSM SHALL set fail=1 and go to FIN; otherwise it SHALL return to GEN.
REQ-019 OUT SHALL hold sample_valid=1 with stable sample_data until sample_valid&&sample_ready; on that handshake accept_cnt += 1 and per-sample rejects clear.
REQ-020 After the OUT handshake, if accept_cnt (post-increment) == num_samples, the FSM SHALL go to FIN; otherwise it SHALL go to GEN.
REQ-021 FIN SHALL last one cycle with done=1, then go to IDLE; done SHALL be a one-cycle pulse per run.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 A start with num_samples=0 SHALL go directly to FIN, with fail=0 and no LFSR advance.
REQ-024 On start, accept_cnt, try_cnt, per-sample rejects and fail SHALL clear; cand_out and the LFSR state SHALL persist across runs.
REQ-025 seed_load with seed_in=0 SHALL load DEF_SEED; if seed_load and start are asserted in the same IDLE cycle, the seed SHALL load first and the run SHALL use it.
REQ-026 start, seed_load and changes to num_samples while busy SHALL be ignored.
REQ-027 try_cnt SHALL saturate at 32'hFFFF_FFFF; accept_cnt cannot overflow because it is bounded by num_samples.
REQ-028 Minimum latency from the start cycle to the first sample_valid SHALL be W/32+2 cycles (W=64: 4 cycles), counting the IDLE->GEN transition, the GEN cycles and CHECK.

Reset
REQ-029 With rst_n=0 at a clock edge: state=IDLE, LFSR=DEF_SEED, cand_out=0, sample_data=0, sample_valid=0, busy=0, done=0, fail=0, accept_cnt=0, try_cnt=0.
REQ-030 Reset asserted mid-run SHALL abort the run with no done pulse, and any pending sample SHALL be dropped.

Verification
REQ-031 Stub checker always 1, W=64, num_samples=3, sample_ready=1 -> 3 samples equal to consecutive LFSR word pairs from DEF_SEED; try_cnt=3; done pulses once; fail=0.
REQ-032 Stub checker always 0, MAX_TRIES=4, num_samples=1 -> try_cnt=4; fail=1; done pulse; no sample_valid.
REQ-033 Checker = cand_out[0], sample_ready held 0 for 10 cycles -> sample_valid and sample_data stay stable for 10 cycles; one sample is accepted on ready, and the LFSR does not advance meanwhile.
REQ-034 start with num_samples=0 -> done in the second cycle; accept_cnt=0; LFSR unchanged.
REQ-035 seed_load with seed_in=0, then start -> output sequence identical to the sequence after reset.
REQ-036 rst_n=0 during OUT -> next cycle sample_valid=0, busy=0 and all counters 0; a fresh start then runs normally.
